// File: rtl/calc_dp_param.sv
// calc_dp_param -- parameterised calculator datapath.
//
// Write-data select mux, DEPTH x WIDTH register file with two gated
// combinational read ports, eight-operation ALU with a multi-cycle shift-add
// multiplier, registered result with Z/C/V flags and a start/busy/done
// handshake toward the controller FSM.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   in1, in2          external operands
//   s1                RF write-data select: 0 in1, 1 in2, 2 zero, 3 res_q
//   we, wa            RF write enable / address
//   rea, raa          read port A enable / address (disabled port reads 0)
//   reb, rab          read port B enable / address
//   c                 ALU opcode, sampled together with start
//   start             one-cycle operation request (ignored while busy)
//   s2                output enable for out
//   busy              multiplier in progress
//   done              one-cycle result-valid pulse
//   out               s2 ? res_q : 0
//   flag_z/c/v        zero, carry/borrow, signed overflow of last result
module calc_dp_param #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       s1,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             rea,
  input  logic             reb,
  input  logic [AW-1:0]    raa,
  input  logic [AW-1:0]    rab,
  input  logic [2:0]       c,
  input  logic             start,
  input  logic             s2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic { S_IDLE, S_MUL } state_t;

  logic [WIDTH-1:0]   r_rf [DEPTH];
  state_t             r_state;
  logic [WIDTH-1:0]   r_res;
  logic               r_fz, r_fc, r_fv;
  logic               r_busy, r_done;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_a, w_b, w_wdata, w_res;
  logic [WIDTH:0]     w_sum, w_diff;
  logic               w_c, w_v;
  logic [2*WIDTH-1:0] w_acc_next;

  // Write-data select; s1=3 feeds back the result currently held in res_q.
  always_comb begin
    case (s1)
      2'd0:    w_wdata = in1;
      2'd1:    w_wdata = in2;
      2'd2:    w_wdata = '0;
      default: w_wdata = r_res;
    endcase
  end

  // NOTE: the register file is cleared by reset because software relies on
  // every entry reading zero afterwards; this forces flops rather than RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (we) begin
      r_rf[wa] <= w_wdata;
    end
  end

  // Reads are combinational from the array, so a same-cycle write to the
  // same address is seen only from the following cycle.
  assign w_a = rea ? r_rf[raa] : '0;
  assign w_b = reb ? r_rf[rab] : '0;

  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};

  // NOTE: every always_comb output gets a default first so no path leaves
  // a variable unassigned and a latch cannot be inferred.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (c)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];          // borrow out: a < b unsigned
        w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_NOT:  w_res = ~w_a;
      OP_PASS: w_res = w_a;
      default: w_res = '0;              // MUL result comes from the FSM
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_res    <= '0;
      r_fz     <= 1'b0;
      r_fc     <= 1'b0;
      r_fv     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (c == OP_MUL) begin
              // Operands are captured so RF traffic during busy is harmless.
              r_mcand  <= {{WIDTH{1'b0}}, w_a};
              r_mplier <= w_b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end else begin
              r_res  <= w_res;
              r_fz   <= (w_res == '0);
              r_fc   <= w_c;
              r_fv   <= w_v;
              r_done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST_ITER) begin
            r_res   <= w_acc_next[WIDTH-1:0];
            r_fz    <= (w_acc_next[WIDTH-1:0] == '0);
            r_fc    <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_fv    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign out    = s2 ? r_res : '0;
  assign flag_z = r_fz;
  assign flag_c = r_fc;
  assign flag_v = r_fv;

endmodule
